// File: rtl/seq_run_tracker.sv
// Tracks strictly-increasing run lengths plus running max/min over a stream of unsigned samples.
// All outputs are registered; the FSM state is exposed on dbg_state for observation.
module seq_run_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] cur_run,
  output logic [CNT_W-1:0] best_run,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic             new_best,
  output logic             dbg_state
);

  // Handshake: in_valid=1 means in_data is consumed on this edge (always ready);
  // out_valid pulses for exactly one cycle after each consumed sample.
  typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] cur_run_q, best_run_q;
  logic [WIDTH-1:0] max_q, min_q;
  logic             out_valid_q, new_best_q;

  logic [CNT_W-1:0] cur_run_d;
  logic [WIDTH-1:0] max_d, min_d;
  logic             better_d;

  always_comb begin
    cur_run_d = CNT_ONE;
    max_d     = in_data;
    min_d     = in_data;
    if (state_q == TRACK) begin
      if (in_data > prev_q)
        cur_run_d = (cur_run_q == CNT_MAX) ? CNT_MAX : cur_run_q + CNT_ONE;
      if (max_q > in_data) max_d = max_q;
      if (min_q < in_data) min_d = min_q;
    end
    better_d = (cur_run_d > best_run_q);
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      cur_run_q   <= '0;
      best_run_q  <= '0;
      max_q       <= '0;
      min_q       <= '0;
      out_valid_q <= 1'b0;
      new_best_q  <= 1'b0;
    end else if (in_valid) begin
      state_q     <= TRACK;
      prev_q      <= in_data;
      cur_run_q   <= cur_run_d;
      max_q       <= max_d;
      min_q       <= min_d;
      out_valid_q <= 1'b1;
      new_best_q  <= better_d;
      if (better_d) best_run_q <= cur_run_d;
    end else begin
      out_valid_q <= 1'b0;
      new_best_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign cur_run   = cur_run_q;
  assign best_run  = best_run_q;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign new_best  = new_best_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_run_tracker.sv
// Table-driven bench for seq_run_tracker, plus a saturation sequence on a narrow-counter instance.
module tb_seq_run_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;

  logic       ov8, nb8, st8;
  logic [7:0] cur8, best8;
  logic [3:0] max8, min8;

  logic       ov3, nb3, st3;
  logic [2:0] cur3, best3;
  logic [3:0] max3, min3;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  seq_run_tracker #(.WIDTH(4), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov8), .cur_run(cur8), .best_run(best8), .max_val(max8), .min_val(min8),
    .new_best(nb8), .dbg_state(st8)
  );

  seq_run_tracker #(.WIDTH(4), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov3), .cur_run(cur3), .best_run(best3), .max_val(max3), .min_val(min3),
    .new_best(nb3), .dbg_state(st3)
  );

  typedef struct {
    logic       rst_n;
    logic       clr;
    logic       vld;
    logic [3:0] data;
    logic       ov;
    logic [7:0] cur;
    logic [7:0] best;
    logic [3:0] mx;
    logic [3:0] mn;
    logic       nb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic r, input logic c, input logic v, input logic [3:0] d);
    reset = r; clear = c; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic c, input logic v, input logic [3:0] d,
                     input logic ov, input int cur, input int best,
                     input int mx, input int mn, input logic nb);
    vec_t t;
    t.rst_n = r; t.clr = c; t.vld = v; t.data = d;
    t.ov = ov; t.cur = 8'(cur); t.best = 8'(best);
    t.mx = 4'(mx); t.mn = 4'(mn); t.nb = nb;
    vecs.push_back(t);
  endtask

  initial begin
    // reset held with a valid sample present: outputs stay zero
    add(0,0,1,4'hF, 0,0,0,0,0,0);
    add(0,0,1,4'hF, 0,0,0,0,0,0);
    add(1,0,1,4'hF, 1,1,1,15,15,1);
    add(1,1,0,4'h0, 0,0,0,0,0,0);
    // 3,5,9,2,4,6,7 back-to-back
    add(1,0,1,4'd3, 1,1,1,3,3,1);
    add(1,0,1,4'd5, 1,2,2,5,3,1);
    add(1,0,1,4'd9, 1,3,3,9,3,1);
    add(1,0,1,4'd2, 1,1,3,9,2,0);
    add(1,0,1,4'd4, 1,2,3,9,2,0);
    add(1,0,1,4'd6, 1,3,3,9,2,0);
    add(1,0,1,4'd7, 1,4,4,9,2,1);
    add(1,0,0,4'd0, 0,4,4,9,2,0);
    add(1,1,0,4'd0, 0,0,0,0,0,0);
    // equal samples with idle gaps
    add(1,0,1,4'd4, 1,1,1,4,4,1);
    add(1,0,0,4'd9, 0,1,1,4,4,0);
    add(1,0,1,4'd4, 1,1,1,4,4,0);
    add(1,0,0,4'd0, 0,1,1,4,4,0);
    add(1,0,1,4'd4, 1,1,1,4,4,0);
    add(1,1,0,4'd0, 0,0,0,0,0,0);
    // clear coinciding with a valid sample discards it
    add(1,0,1,4'd1, 1,1,1,1,1,1);
    add(1,0,1,4'd2, 1,2,2,2,1,1);
    add(1,0,1,4'd3, 1,3,3,3,1,1);
    add(1,1,1,4'd8, 0,0,0,0,0,0);
    add(1,0,1,4'd2, 1,1,1,2,2,1);
    add(1,1,0,4'd0, 0,0,0,0,0,0);
    // reset mid-run loses history
    add(1,0,1,4'd1, 1,1,1,1,1,1);
    add(1,0,1,4'd2, 1,2,2,2,1,1);
    add(1,0,1,4'd3, 1,3,3,3,1,1);
    add(0,0,0,4'd0, 0,0,0,0,0,0);
    add(1,0,1,4'd5, 1,1,1,5,5,1);

    reset = 1'b0;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].clr, vecs[i].vld, vecs[i].data);
      chk("out_valid", i, int'(ov8),   int'(vecs[i].ov));
      chk("cur_run",   i, int'(cur8),  int'(vecs[i].cur));
      chk("best_run",  i, int'(best8), int'(vecs[i].best));
      chk("max_val",   i, int'(max8),  int'(vecs[i].mx));
      chk("min_val",   i, int'(min8),  int'(vecs[i].mn));
      chk("new_best",  i, int'(nb8),   int'(vecs[i].nb));
    end

    // saturation on the 3-bit counter instance, ascending 0..15
    step(1, 1, 0, 4'd0);
    chk("state_after_clear", 0, int'(st3), 0);
    chk("cur3_after_clear", 0, int'(cur3), 0);
    for (int i = 0; i < 16; i++) begin
      int exp_run;
      exp_run = (i + 1 > 7) ? 7 : i + 1;
      step(1, 0, 1, 4'(i));
      chk("sat_state", i, int'(st3), 1);
      chk("sat_ov", i, int'(ov3), 1);
      chk("sat_cur", i, int'(cur3), exp_run);
      chk("sat_best", i, int'(best3), exp_run);
      chk("sat_new_best", i, int'(nb3), (i + 1 <= 7) ? 1 : 0);
      chk("sat_max", i, int'(max3), i);
      chk("sat_min", i, int'(min3), 0);
      chk("wide_cur", i, int'(cur8), i + 1);
    end
    step(1, 0, 1, 4'd15);
    chk("sat_equal_cur", 0, int'(cur3), 1);
    chk("sat_equal_best", 0, int'(best3), 7);
    chk("sat_equal_nb", 0, int'(nb3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
